lsu_bus_ctrl: RTL and testbench

Load/store unit sitting directly downstream of the instruction decoder in the single-cycle core. It consumes the decoder's data-memory controls (dmem_req, dmem_wr, dmem_size, dmem_zero_ex), the ALU address and the rs2 store data. It runs a req/gnt/rvalid handshake on the data bus, stalling the core until the access completes. It returns byte-lane-extracted, sign- or zero-extended load data to the register-file write mux, and flags misaligned accesses and bus timeouts.

---
 rtl/lsu_bus_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lsu_bus_ctrl
// Description : Load/store unit bus controller. Issues req/gnt/rvalid data-bus
//               accesses for decoded loads and stores, stalls the core until
//               completion, extracts and extends load data, and flags
//               misaligned accesses and bus timeouts.
// Revision    : 1.0 - initial release
// ============================================================================

package lsu_bus_ctrl_pkg;
    typedef enum logic [1:0] {
        OP_DMEM_BYTE = 2'd0,
        OP_DMEM_HALF = 2'd1,
        OP_DMEM_WORD = 2'd2
    } op_enum_dmem_size;
endpackage

module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dmem_req,
    input  logic             dmem_wr,
    input  op_enum_dmem_size dmem_size,
    input  logic             dmem_zero_ex,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             lsu_stall,
    output logic [31:0]      lsu_rdata,
    output logic             lsu_misalign,
    output logic             lsu_err,
    output logic             bus_req,
    output logic             bus_we,
    output logic [31:0]      bus_addr,
    output logic [3:0]       bus_be,
    output logic [31:0]      bus_wdata,
    input  logic             bus_gnt,
    input  logic             bus_rvalid,
    input  logic [31:0]      bus_rdata
);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_WAIT_GNT    = 2'd1;
    localparam logic [1:0] c_WAIT_RVALID = 2'd2;
    localparam logic [1:0] c_DONE        = 2'd3;

    // One spare count beyond TIMEOUT_CYC-1 covers a gnt arriving on the last
    // allowed wait cycle of a load.
    localparam int               c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic               r_wr;
    op_enum_dmem_size   r_size;
    logic               r_zero_ex;
    logic [31:0]        r_rdata;
    logic               r_err;

    logic               w_idle;
    logic               w_misaligned;
    logic               w_issue;
    logic               w_timeout;
    logic [31:0]        w_src_addr;
    logic [31:0]        w_src_wdata;
    op_enum_dmem_size   w_src_size;
    logic [31:0]        w_shifted;
    logic [31:0]        w_load_val;

    assign w_idle       = (r_state == c_IDLE);
    assign w_misaligned = ((dmem_size == OP_DMEM_HALF) && addr[0]) ||
                          ((dmem_size == OP_DMEM_WORD) && (addr[1:0] != 2'b00));
    assign w_issue      = ~rst & w_idle & dmem_req & ~w_misaligned;

    assign lsu_misalign = ~rst & w_idle & dmem_req & w_misaligned;
    assign bus_req      = ~rst & (w_issue | (r_state == c_WAIT_GNT));
    assign lsu_stall    = ~rst & (w_issue | (r_state == c_WAIT_GNT) |
                                  (r_state == c_WAIT_RVALID));
    assign lsu_rdata    = r_rdata;
    assign lsu_err      = r_err;

    // Bus fields: live decoder inputs on the issue cycle, latched copy while waiting
    always_comb begin
        w_src_addr  = w_idle ? addr  : r_addr;
        w_src_wdata = w_idle ? wdata : r_wdata;
        w_src_size  = w_idle ? dmem_size : r_size;
        bus_we      = w_idle ? dmem_wr : r_wr;
        bus_addr    = {w_src_addr[31:2], 2'b00};
        case (w_src_size)
            OP_DMEM_BYTE: begin
                bus_be    = 4'b0001 << w_src_addr[1:0];
                bus_wdata = {4{w_src_wdata[7:0]}};
            end
            OP_DMEM_HALF: begin
                bus_be    = 4'b0011 << w_src_addr[1:0];
                bus_wdata = {2{w_src_wdata[15:0]}};
            end
            default: begin
                bus_be    = 4'b1111;
                bus_wdata = w_src_wdata;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension using the latched request
    always_comb begin
        w_shifted = bus_rdata >> {r_addr[1:0], 3'b000};
        case (r_size)
            OP_DMEM_BYTE: w_load_val = {{24{~r_zero_ex & w_shifted[7]}},  w_shifted[7:0]};
            OP_DMEM_HALF: w_load_val = {{16{~r_zero_ex & w_shifted[15]}}, w_shifted[15:0]};
            default:      w_load_val = w_shifted;
        endcase
    end

    // Next-state logic; an awaited handshake wins over the timeout
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_issue) begin
                    if (bus_gnt) w_next_state = dmem_wr ? c_DONE : c_WAIT_RVALID;
                    else         w_next_state = c_WAIT_GNT;
                end
            end
            c_WAIT_GNT: begin
                if (bus_gnt) begin
                    w_next_state = r_wr ? c_DONE : c_WAIT_RVALID;
                end else if (r_cnt >= c_CNT_LAST) begin
                    w_next_state = c_DONE;
                    w_timeout    = 1'b1;
                end
            end
            c_WAIT_RVALID: begin
                if (bus_rvalid) begin
                    w_next_state = c_DONE;
                end else if (r_cnt >= c_CNT_LAST) begin
                    w_next_state = c_DONE;
                    w_timeout    = 1'b1;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // State, timeout counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_cnt <= '0;
            end else if ((r_state == c_WAIT_GNT) || (r_state == c_WAIT_RVALID)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err   <= 1'b1;
                r_rdata <= 32'd0;
            end else begin
                if ((w_next_state != r_state) && (w_next_state != c_IDLE)) begin
                    r_err <= 1'b0;
                end
                if ((r_state == c_WAIT_RVALID) && bus_rvalid) begin
                    r_rdata <= w_load_val;
                end
            end
        end
    end

    // Capture the request on issue so the decoder inputs may change while stalled
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_addr    <= addr;
            r_wdata   <= wdata;
            r_wr      <= dmem_wr;
            r_size    <= dmem_size;
            r_zero_ex <= dmem_zero_ex;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_bus_ctrl
// Description : Directed self-checking bench for lsu_bus_ctrl with a
//               transaction-level expectation model and a per-cycle compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_bus_ctrl;
    import lsu_bus_ctrl_pkg::*;

    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             dmem_req;
    logic             dmem_wr;
    op_enum_dmem_size dmem_size;
    logic             dmem_zero_ex;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic             lsu_stall;
    logic [31:0]      lsu_rdata;
    logic             lsu_misalign;
    logic             lsu_err;
    logic             bus_req;
    logic             bus_we;
    logic [31:0]      bus_addr;
    logic [3:0]       bus_be;
    logic [31:0]      bus_wdata;
    logic             bus_gnt;
    logic             bus_rvalid;
    logic [31:0]      bus_rdata;

    lsu_bus_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_size(dmem_size),
        .dmem_zero_ex(dmem_zero_ex), .addr(addr), .wdata(wdata),
        .lsu_stall(lsu_stall), .lsu_rdata(lsu_rdata), .lsu_misalign(lsu_misalign),
        .lsu_err(lsu_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle
    logic        en_cmp = 1'b0;
    logic        e_req, e_stall, e_mis, e_bus_valid, e_res_valid, e_we, e_err;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_be;
    // Architectural result state of the model
    logic [31:0] m_rdata = 32'd0;
    logic        m_err   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input op_enum_dmem_size s);
        case (s)
            OP_DMEM_BYTE: return 1;
            OP_DMEM_HALF: return 2;
            default:      return 4;
        endcase
    endfunction

    function automatic logic [3:0] mdl_be(input op_enum_dmem_size s, input logic [31:0] a);
        int n = nbytes(s);
        int off = (n == 4) ? 0 : int'(a[1:0]);
        logic [3:0] be;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] mdl_wdata(input op_enum_dmem_size s, input logic [31:0] wd);
        int n = nbytes(s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_load(input op_enum_dmem_size s, input logic zx,
                                             input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(s);
        int off = (n == 4) ? 0 : int'(a[1:0]);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(rd[8*(off+i) +: 8]) << (8*i));
        if (!zx && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    // Per-cycle comparison against the model's expectations
    always @(negedge clk) begin
        if (en_cmp) begin
            chk("bus_req", {31'd0, bus_req}, {31'd0, e_req});
            chk("lsu_stall", {31'd0, lsu_stall}, {31'd0, e_stall});
            chk("lsu_misalign", {31'd0, lsu_misalign}, {31'd0, e_mis});
            if (e_bus_valid) begin
                chk("bus_we", {31'd0, bus_we}, {31'd0, e_we});
                chk("bus_addr", bus_addr, e_addr);
                chk("bus_be", {28'd0, bus_be}, {28'd0, e_be});
                chk("bus_wdata", bus_wdata, e_wdata);
            end
            if (e_res_valid) begin
                chk("lsu_rdata", lsu_rdata, e_rdata);
                chk("lsu_err", {31'd0, lsu_err}, {31'd0, e_err});
            end
        end
    end

    // One memory access. gc: cycle of gnt (0 = issue cycle, <0 never);
    // rv: cycles after gnt until rvalid (0 = next cycle, <0 never).
    task automatic access(input logic wr, input op_enum_dmem_size sz, input logic zx,
                          input logic [31:0] a, input logic [31:0] wd, input int gc,
                          input int rv, input logic [31:0] rd, input logic late);
        int  c = 0;
        int  rc = (gc < 0 || rv < 0) ? -1 : gc + 1 + rv;
        logic done, tout;
        @(posedge clk); #1;
        dmem_req = 1'b1; dmem_wr = wr; dmem_size = sz; dmem_zero_ex = zx;
        addr = a; wdata = wd;
        bus_gnt = (gc == 0); bus_rvalid = 1'b0; bus_rdata = ~rd;
        e_req = 1'b1; e_stall = 1'b1; e_mis = 1'b0; e_bus_valid = 1'b1; e_res_valid = 1'b0;
        e_we = wr; e_addr = {a[31:2], 2'b00}; e_be = mdl_be(sz, a); e_wdata = mdl_wdata(sz, wd);
        done = (gc == 0) && wr;
        tout = 1'b0;
        while (!done) begin
            @(posedge clk); #1;
            c++;
            addr = $urandom; wdata = $urandom; dmem_wr = ~wr; dmem_zero_ex = ~zx;
            dmem_size = op_enum_dmem_size'(2'($urandom_range(0, 2)));
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = ~rd;
            if (gc < 0 || c <= gc) begin
                e_req = 1'b1; e_stall = 1'b1; e_bus_valid = 1'b1;
                if (c == gc) begin
                    bus_gnt = 1'b1;
                    if (wr) done = 1'b1;
                end else if (c >= TO) begin
                    tout = 1'b1; done = 1'b1;
                end
            end else begin
                e_req = 1'b0; e_stall = 1'b1; e_bus_valid = 1'b0;
                if (c == rc) begin
                    bus_rvalid = 1'b1; bus_rdata = rd; done = 1'b1;
                end else if (c >= TO) begin
                    tout = 1'b1; done = 1'b1;
                end
            end
        end
        if (tout) begin
            m_err = 1'b1; m_rdata = 32'd0;
        end else begin
            m_err = 1'b0;
            if (!wr) m_rdata = mdl_load(sz, zx, a, rd);
        end
        // DONE: dmem_req still high but must be ignored
        @(posedge clk); #1;
        bus_gnt = late; bus_rvalid = late; bus_rdata = 32'hCAFEF00D;
        e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0; e_bus_valid = 1'b0;
        e_res_valid = 1'b1; e_rdata = m_rdata; e_err = m_err;
        // Following IDLE cycle with no request
        @(posedge clk); #1;
        dmem_req = 1'b0;
    endtask

    task automatic misaligned(input logic wr, input op_enum_dmem_size sz, input logic [31:0] a);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            dmem_req = 1'b1; dmem_wr = wr; dmem_size = sz; addr = a; wdata = $urandom;
            bus_gnt = 1'b1; bus_rvalid = 1'b0;
            e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b1; e_bus_valid = 1'b0; e_res_valid = 1'b0;
        end
        @(posedge clk); #1;
        dmem_req = 1'b0; bus_gnt = 1'b0;
        e_mis = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dmem_req = 1'b1; dmem_wr = 1'b0; dmem_size = OP_DMEM_WORD;
        dmem_zero_ex = 1'b0; addr = 32'h1001; wdata = 32'd0;
        bus_gnt = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        e_req = 1'b0; e_stall = 1'b0; e_mis = 1'b0; e_bus_valid = 1'b0; e_res_valid = 1'b0;
        e_we = 1'b0; e_err = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_rdata = 32'd0; e_be = 4'd0;
        en_cmp = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; dmem_req = 1'b0; bus_gnt = 1'b0;
        @(negedge clk);
        chk("reset_rdata", lsu_rdata, 32'h0);
        chk("reset_err", {31'd0, lsu_err}, 32'h0);

        // Zero-wait store word
        fork
            access(1'b1, OP_DMEM_WORD, 1'b0, 32'h1000, 32'hDEADBEEF, 0, 0, 32'h0, 1'b0);
            begin
                @(posedge clk); @(negedge clk);
                chk("sw_be", {28'd0, bus_be}, 32'hF);
                chk("sw_addr", bus_addr, 32'h1000);
                chk("sw_stall_issue", {31'd0, lsu_stall}, 32'h1);
                @(negedge clk);
                chk("sw_stall_done", {31'd0, lsu_stall}, 32'h0);
            end
        join

        // Store byte, gnt after 3 wait cycles, bus fields held
        fork
            access(1'b1, OP_DMEM_BYTE, 1'b0, 32'h1003, 32'h000000A5, 3, 0, 32'h0, 1'b0);
            begin
                @(posedge clk);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("sb_be", {28'd0, bus_be}, 32'h8);
                    chk("sb_wdata", bus_wdata, 32'hA5A5A5A5);
                end
            end
        join

        access(1'b0, OP_DMEM_BYTE, 1'b0, 32'h2002, 32'h0, 0, 0, 32'h12F45678, 1'b0);
        @(negedge clk); chk("lb_rdata", lsu_rdata, 32'hFFFFFFF4);
        access(1'b0, OP_DMEM_BYTE, 1'b1, 32'h2002, 32'h0, 1, 2, 32'h12F45678, 1'b0);
        @(negedge clk); chk("lbu_rdata", lsu_rdata, 32'h000000F4);
        access(1'b0, OP_DMEM_HALF, 1'b0, 32'h2002, 32'h0, 2, 0, 32'h12F45678, 1'b0);
        @(negedge clk); chk("lh_rdata", lsu_rdata, 32'h000012F4);
        access(1'b0, OP_DMEM_HALF, 1'b0, 32'h2000, 32'h0, 0, 1, 32'h00008001, 1'b0);
        access(1'b0, OP_DMEM_HALF, 1'b1, 32'h2002, 32'h0, 1, 0, 32'h80010000, 1'b0);
        access(1'b0, OP_DMEM_BYTE, 1'b0, 32'h2001, 32'h0, 0, 0, 32'h00008000, 1'b0);
        access(1'b1, OP_DMEM_HALF, 1'b0, 32'h1002, 32'h1234BEEF, 1, 0, 32'h0, 1'b0);

        // Misaligned accesses stay in IDLE with no bus activity
        misaligned(1'b0, OP_DMEM_WORD, 32'h2001);
        misaligned(1'b0, OP_DMEM_HALF, 32'h2003);
        misaligned(1'b1, OP_DMEM_WORD, 32'h1002);
        access(1'b0, OP_DMEM_WORD, 1'b0, 32'h2004, 32'h0, 0, 0, 32'h01234567, 1'b0);

        // Timeout boundaries: handshake on the last allowed cycle still succeeds
        access(1'b0, OP_DMEM_WORD, 1'b0, 32'h200C, 32'h0, 5, 10, 32'h55AA33CC, 1'b0);
        access(1'b1, OP_DMEM_WORD, 1'b0, 32'h1008, 32'h11112222, 16, 0, 32'h0, 1'b0);

        // Load with gnt but no rvalid, then a late rvalid
        access(1'b0, OP_DMEM_WORD, 1'b0, 32'h2008, 32'h0, 0, -1, 32'h77777777, 1'b1);
        @(negedge clk);
        chk("to_load_rdata", lsu_rdata, 32'h0);
        chk("to_load_err", {31'd0, lsu_err}, 32'h1);
        access(1'b0, OP_DMEM_WORD, 1'b0, 32'h200C, 32'h0, 5, 11, 32'h66666666, 1'b0);

        // Stuck bus: no gnt at all, stall length is TIMEOUT_CYC+1
        fork
            access(1'b1, OP_DMEM_WORD, 1'b0, 32'h1010, 32'h33334444, -1, 0, 32'h0, 1'b1);
            begin
                int cnt = 0;
                @(posedge clk);
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    if (lsu_stall) cnt++;
                    else break;
                end
                chk("stuck_stall_cycles", cnt, 32'd17);
            end
        join
        access(1'b1, OP_DMEM_WORD, 1'b0, 32'h1014, 32'h0BADF00D, 17, 0, 32'h0, 1'b0);

        // Reset while waiting for rvalid
        access(1'b0, OP_DMEM_WORD, 1'b0, 32'h2000, 32'h0, 0, 0, 32'h89ABCDEF, 1'b0);
        @(posedge clk); #1;
        dmem_req = 1'b1; dmem_wr = 1'b0; dmem_size = OP_DMEM_WORD; dmem_zero_ex = 1'b0;
        addr = 32'h3000; bus_gnt = 1'b1; bus_rvalid = 1'b0;
        e_req = 1'b1; e_stall = 1'b1; e_mis = 1'b0; e_bus_valid = 1'b1; e_res_valid = 1'b0;
        e_we = 1'b0; e_addr = 32'h3000; e_be = 4'hF; e_wdata = wdata;
        @(posedge clk); #1;
        dmem_req = 1'b0; bus_gnt = 1'b0; rst = 1'b1;
        e_req = 1'b0; e_stall = 1'b0; e_bus_valid = 1'b0;
        @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'h0);
        chk("rst_stall", {31'd0, lsu_stall}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_rdata = 32'd0; m_err = 1'b0;
        e_res_valid = 1'b1; e_rdata = 32'd0; e_err = 1'b0;
        @(negedge clk);
        chk("rst_rdata", lsu_rdata, 32'h0);
        chk("rst_err", {31'd0, lsu_err}, 32'h0);
        access(1'b1, OP_DMEM_WORD, 1'b0, 32'h1000, 32'h12345678, 0, 0, 32'h0, 1'b0);

        @(posedge clk); #1;
        en_cmp = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
